rr_xor_unit_arbiter: RTL and testbench
======================================

Name: rr_xor_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one mux-built W-bit XOR datapath among N_REQ requesters.
- Each requester raises req with its operand pair.
- The arbiter grants one requester at a time, latches that requester's operands and occupies the unit for LAT cycles.
- It then returns the registered result with a one-cycle done pulse to the winner.
- It sits between client blocks and the shared combinational gate unit; the unit is instantiated inside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand/result width in bits.
- LAT, 2, cycles the shared unit is held per operation (>=1).

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request, level.
- a_flat  input  N_REQ*W  operand A; requester i owns bits [i*W +: W].
- b_flat  input  N_REQ*W  operand B; same packing.
- gnt  output  N_REQ  one-hot grant, high while the unit serves that requester.
- done  output  N_REQ  one-hot, single-cycle completion pulse.
- res  output  W  result of the last completed operation.
- busy  output  1  high while in BUSY.

Behaviour:
- Reset: gnt=0, done=0, res=0, busy=0, state=IDLE, priority pointer ptr=0, cycle counter=0.
- Reset asserted mid-operation aborts it in that cycle; no done is issued and res returns to 0.
- States: IDLE, BUSY.
- IDLE, no req bit set: stay in IDLE, outputs held, done=0.
- IDLE, any req bit set at a clock edge:
  - Winner = first set bit scanning ptr, ptr+1, ..., wrapping mod N_REQ.
  - Latch the winner's a and b into internal regs.
  - gnt=onehot(winner), busy=1, counter=LAT-1, state=BUSY.
- BUSY, counter!=0: counter decrements; gnt and busy held.
- BUSY, counter==0, at the next edge:
  - res <= a_reg XOR b_reg, computed by the shared mux-only XOR (per bit: not_a = a ? 0 : 1; out = b ? not_a : a).
  - done=onehot(winner) for exactly one cycle.
  - gnt=0, busy=0, ptr=(winner+1) mod N_REQ, state=IDLE.
- Timing:
  - req first sampled at edge k in IDLE -> gnt high from edge k to edge k+LAT.
  - done and res valid after edge k+LAT.
  - Earliest next grant is edge k+LAT+1.
  - Throughput: one operation per LAT+1 cycles.
- Operands are sampled only at the grant edge; later changes to a_flat/b_flat or req do not affect the operation in flight.
- req deasserting during BUSY does not cancel the operation; done still pulses.
- The requester must drop req in the done cycle; req still high at the next IDLE edge counts as a new request, subject to rotated priority.
- res holds its value until the next completion.
- Simultaneous requests: only one grant per arbitration edge; the others wait with req held. No request waits more than N_REQ-1 foreign operations (starvation-free).
- New req arriving while BUSY is not granted until IDLE.
- A req bit pulsed only during BUSY and dropped before IDLE is never served.
- Invariants: gnt and done are each zero or one-hot; gnt and done are never high in the same cycle; busy == |gnt.

Test Plan:
- Reset release, N_REQ=4, W=8, LAT=2, no req -> gnt=0, done=0, res=8'h00, busy=0 for 10 cycles.
- Single requester: req[2]=1, a=8'hA5, b=8'h0F at edge k -> gnt=4'b0100 for 2 cycles; after edge k+2: done=4'b0100 for 1 cycle, res=8'hAA.
- All four requesting, held until done, with a_i=8'h10*i and b_i=8'hFF:
  - Grant order is 0,1,2,3, spaced 3 cycles apart.
  - Results are 8'hFF, 8'hEF, 8'hDF, 8'hCF.
  - Then with req[0] and req[3] still held, order continues 0, 3, 0.
- Operand change during BUSY: grant req[1] with a=8'h33, b=8'h55, then change a to 8'h00 next cycle -> res=8'h66.
- Reset during BUSY: assert rst one cycle after grant -> no done pulse, gnt=0, res=0, busy=0; the next req[3] is still won by requester 0 if req[0] is also set, since ptr=0.
- LAT=1 rebuild with req[0] held permanently -> done[0] pulses every 2 cycles, never coincident with gnt; all 4 input combinations per bit give res = a^b.

Source files
------------

// File: rtl/rr_xor_unit_arbiter.sv
// Round-robin arbiter that time-shares one mux-built XOR unit among N_REQ requesters.
// A grant latches the winner's operands, holds the unit for LAT cycles, then pulses done with the result.
module rr_xor_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_flat,
  input  logic [N_REQ*W-1:0] b_flat,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       res,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] win_nxt;
  logic [PW-1:0] idx;
  logic          found;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_p0;
  logic [W-1:0]  b_p0;
  logic [W-1:0]  xor_y;

  // First set request scanning from ptr upward, wrapping.
  always_comb begin
    found   = 1'b0;
    win_nxt = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_nxt = idx;
      end
    end
  end

  // Stage p0: operands captured only at the grant edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      a_p0 <= a_flat[win_nxt*W +: W];
      b_p0 <= b_flat[win_nxt*W +: W];
    end
  end

  rr_xor_gate_unit #(.W(W)) u_xor (
    .a (a_p0),
    .b (b_p0),
    .y (xor_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      res   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
      win   <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            win   <= win_nxt;
            gnt   <= ONE << win_nxt;
            busy  <= 1'b1;
            cnt   <= CW'(LAT - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res   <= xor_y;
            done  <= ONE << win;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Shared combinational XOR built only from 2:1 muxes.
module rr_xor_gate_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic not_a;
    assign not_a = a[i] ? 1'b0 : 1'b1;
    assign y[i]  = b[i] ? not_a : a[i];
  end

endmodule

// File: tb/tb_rr_xor_unit_arbiter.sv
// Scoreboard bench for rr_xor_unit_arbiter: stimulus queues expected done/res, monitors pop on each done pulse.
module tb_rr_xor_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req1;
  logic [31:0] a_flat, b_flat, a1_flat, b1_flat;
  logic [3:0]  gnt, done, gnt1, done1;
  logic [7:0]  res, res1;
  logic        busy, busy1;

  typedef struct packed {
    logic [3:0] d;
    logic [7:0] r;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   compared = 0;
  int   mismatched = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  rr_xor_unit_arbiter #(.N_REQ(4), .W(8), .LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .done(done), .res(res), .busy(busy)
  );

  rr_xor_unit_arbiter #(.N_REQ(4), .W(8), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .a_flat(a1_flat), .b_flat(b1_flat),
    .gnt(gnt1), .done(done1), .res(res1), .busy(busy1)
  );

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: invariants every cycle, scoreboard pop on each done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      compared++;
      if (!$onehot0(gnt) || !$onehot0(done) || ((gnt & done) != 4'b0) || (busy !== (|gnt))) begin
        mismatched++;
        $display("FAIL inv_lat2: gnt=%b done=%b busy=%b", gnt, done, busy);
      end
      if (done !== 4'b0) begin
        compared++;
        if (q0.size() == 0) begin
          mismatched++;
          $display("FAIL sb_lat2: unexpected done=%b res=%h", done, res);
        end else begin
          exp_t e;
          e = q0.pop_front();
          if (done !== e.d || res !== e.r) begin
            mismatched++;
            $display("FAIL sb_lat2: got done=%b res=%h expected done=%b res=%h", done, res, e.d, e.r);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      compared++;
      if (!$onehot0(gnt1) || !$onehot0(done1) || ((gnt1 & done1) != 4'b0) || (busy1 !== (|gnt1))) begin
        mismatched++;
        $display("FAIL inv_lat1: gnt=%b done=%b busy=%b", gnt1, done1, busy1);
      end
      if (done1 !== 4'b0) begin
        compared++;
        if (q1.size() == 0) begin
          mismatched++;
          $display("FAIL sb_lat1: unexpected done=%b res=%h", done1, res1);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if (done1 !== e.d || res1 !== e.r) begin
            mismatched++;
            $display("FAIL sb_lat1: got done=%b res=%h expected done=%b res=%h", done1, res1, e.d, e.r);
          end
        end
      end
    end
  end

  // One LAT=2 operation: grant one edge after request, done LAT edges later.
  task automatic op(input int w, input logic [7:0] r, input logic [3:0] nreq);
    exp_t e;
    e.d = oh(w);
    e.r = r;
    q0.push_back(e);
    tick(1);
    check($sformatf("grant_%0d", w), {28'b0, gnt}, {28'b0, oh(w)});
    tick(2);
    check($sformatf("done_%0d", w), {20'b0, gnt, done, res}, {20'b0, 4'b0, oh(w), r});
    req = nreq;
  endtask

  initial begin
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [7:0] pr [4];
    exp_t e;
    pa[0] = 8'h33; pb[0] = 8'h55; pr[0] = 8'h66;
    pa[1] = 8'hFF; pb[1] = 8'h00; pr[1] = 8'hFF;
    pa[2] = 8'h00; pb[2] = 8'hFF; pr[2] = 8'hFF;
    pa[3] = 8'hA5; pb[3] = 8'hA5; pr[3] = 8'h00;

    rst = 1'b1; req = '0; req1 = '0;
    a_flat = '0; b_flat = '0; a1_flat = '0; b1_flat = '0;
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle", {15'b0, gnt, done, res, busy}, 32'h0);
    end

    // Single requester 2.
    a_flat[16 +: 8] = 8'hA5;
    b_flat[16 +: 8] = 8'h0F;
    req = 4'b0100;
    op(2, 8'hAA, 4'b0000);
    tick(1);
    check("res_hold", {20'b0, gnt, done, res}, {20'b0, 4'b0, 4'b0, 8'hAA});

    // Fresh pointer, then all four requesting.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_flat[i*8 +: 8] = 8'h10 * i;
      b_flat[i*8 +: 8] = 8'hFF;
    end
    req = 4'b1111;
    op(0, 8'hFF, 4'b1110);
    op(1, 8'hEF, 4'b1100);
    op(2, 8'hDF, 4'b1000);
    op(3, 8'hCF, 4'b1001);
    op(0, 8'hFF, 4'b1001);
    op(3, 8'hCF, 4'b1001);
    op(0, 8'hFF, 4'b0000);

    // Operand change while busy is ignored.
    a_flat[8 +: 8] = 8'h33;
    b_flat[8 +: 8] = 8'h55;
    req = 4'b0010;
    e.d = 4'b0010;
    e.r = 8'h66;
    q0.push_back(e);
    tick(1);
    check("chg_grant", {28'b0, gnt}, 32'h2);
    a_flat[8 +: 8] = 8'h00;
    tick(2);
    check("chg_done", {20'b0, gnt, done, res}, {20'b0, 4'b0, 4'b0010, 8'h66});
    req = 4'b0000;

    // Reset mid-operation aborts it and clears the pointer.
    tick(1);
    req = 4'b0100;
    tick(1);
    check("abort_grant", {28'b0, gnt}, 32'h4);
    rst = 1'b1;
    req = 4'b0000;
    tick(1);
    check("abort_state", {15'b0, gnt, done, res, busy}, 32'h0);
    rst = 1'b0;
    tick(2);
    check("abort_nodone", {15'b0, gnt, done, res, busy}, 32'h0);
    req = 4'b1001;
    op(0, 8'hFF, 4'b0000);

    // LAT=1 instance, requester 0 held continuously.
    a1_flat[7:0] = pa[0];
    b1_flat[7:0] = pb[0];
    e.d = 4'b0001;
    e.r = pr[0];
    q1.push_back(e);
    req1 = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      tick(1);
      check($sformatf("l1_grant_%0d", j), {24'b0, gnt1, done1}, {24'b0, 4'b0001, 4'b0000});
      tick(1);
      check($sformatf("l1_done_%0d", j), {20'b0, gnt1, done1, res1}, {20'b0, 4'b0000, 4'b0001, pr[j]});
      if (j < 3) begin
        a1_flat[7:0] = pa[j+1];
        b1_flat[7:0] = pb[j+1];
        e.r = pr[j+1];
        q1.push_back(e);
      end else begin
        req1 = 4'b0000;
      end
    end

    tick(3);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
